// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: load encodings, FSM states and
// the byte-offset width helper.
package wb_pkg;

  typedef enum logic [2:0] {
    LT_LW    = 3'd0,
    LT_LB    = 3'd1,
    LT_LBU   = 3'd2,
    LT_LH    = 3'd3,
    LT_LHU   = 3'd4,
    LT_LWS32 = 3'd5,
    LT_LWU32 = 3'd6
  } load_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int LT_W = 3;

  function automatic int off_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Little-endian sub-word extraction with sign/zero extension for loads.
// Low offset bits below the access size are ignored.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = off_width(DATA_W)
) (
  input  logic [LT_W-1:0]   load_type,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  localparam int NB = DATA_W / 8;

  logic [7:0]        lane [NB];
  logic [OFF_W-1:0]  off_h;
  logic [OFF_W-1:0]  off_w;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       word_v;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] word_u;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane[gi] = rdata[gi*8 +: 8];
  end

  assign off_h  = byte_off & ~OFF_W'(1);
  assign off_w  = byte_off & ~OFF_W'(3);
  assign byte_v = lane[byte_off];
  assign half_v = {lane[off_h | OFF_W'(1)], lane[off_h]};
  assign word_v = {lane[off_w | OFF_W'(3)], lane[off_w | OFF_W'(2)],
                   lane[off_w | OFF_W'(1)], lane[off_w]};

  // On a 32-bit datapath the 32-bit word forms collapse to the full word.
  if (DATA_W > 32) begin : g_word_ext
    assign word_s = {{(DATA_W-32){word_v[31]}}, word_v};
    assign word_u = {{(DATA_W-32){1'b0}}, word_v};
  end else begin : g_word_full
    assign word_s = word_v;
    assign word_u = word_v;
  end

  always_comb begin
    data = rdata;
    case (load_type)
      LT_LB:    data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LT_LBU:   data = {{(DATA_W-8){1'b0}}, byte_v};
      LT_LH:    data = {{(DATA_W-16){half_v[15]}}, half_v};
      LT_LHU:   data = {{(DATA_W-16){1'b0}}, half_v};
      LT_LWS32: data = word_s;
      LT_LWU32: data = word_u;
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: valid/ready intake, holds a load until memory data
// returns, drives a registered regfile write, counts retirements.
module wb_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_W-1:0]            in_alu_i,
  input  logic [REG_AW-1:0]            in_rd_i,
  input  logic                         in_reg_write_i,
  input  logic                         in_mem_to_reg_i,
  input  logic [2:0]                   in_load_type_i,
  input  logic [off_width(DATA_W)-1:0] in_byte_off_i,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic                         wb_we_o,
  output logic [REG_AW-1:0]            wb_addr_o,
  output logic [DATA_W-1:0]            wb_data_o,
  output logic [CNT_W-1:0]             retire_cnt_o,
  output logic                         protocol_err_o
);

  localparam int OFF_W = off_width(DATA_W);

  state_e            state_reg;
  logic [REG_AW-1:0] pend_rd_reg;
  logic              pend_we_reg;
  logic [LT_W-1:0]   pend_lt_reg;
  logic [OFF_W-1:0]  pend_off_reg;
  logic              we_reg;
  logic [REG_AW-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;

  logic              in_wait;
  logic              accept;
  logic              complete;
  logic              stray;
  logic              we_next;
  logic [REG_AW-1:0] sel_rd;
  logic              sel_we;
  logic [LT_W-1:0]   sel_lt;
  logic [OFF_W-1:0]  sel_off;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] result;

  assign in_wait    = (state_reg == ST_WAIT);
  assign in_ready_o = !in_wait && !rst_i;
  assign accept     = in_valid_i && in_ready_o;

  // While waiting, the captured fields describe the instruction being completed.
  assign sel_rd  = in_wait ? pend_rd_reg  : in_rd_i;
  assign sel_we  = in_wait ? pend_we_reg  : in_reg_write_i;
  assign sel_lt  = in_wait ? pend_lt_reg  : in_load_type_i;
  assign sel_off = in_wait ? pend_off_reg : in_byte_off_i;

  wb_load_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .load_type (sel_lt),
    .byte_off  (sel_off),
    .rdata     (mem_rdata_i),
    .data      (aligned)
  );

  assign complete = in_wait ? mem_rvalid_i
                            : (accept && (!in_mem_to_reg_i || mem_rvalid_i));
  assign result   = (!in_wait && !in_mem_to_reg_i) ? in_alu_i : aligned;
  assign stray    = !in_wait && mem_rvalid_i && !(accept && in_mem_to_reg_i);
  assign we_next  = complete && sel_we && (sel_rd != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      pend_rd_reg  <= '0;
      pend_we_reg  <= 1'b0;
      pend_lt_reg  <= '0;
      pend_off_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      we_reg <= we_next;
      if (complete) begin
        addr_reg <= sel_rd;
        data_reg <= result;
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end
      if (stray) err_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (accept && in_mem_to_reg_i && !mem_rvalid_i) begin
            state_reg    <= ST_WAIT;
            pend_rd_reg  <= in_rd_i;
            pend_we_reg  <= in_reg_write_i;
            pend_lt_reg  <= in_load_type_i;
            pend_off_reg <= in_byte_off_i;
          end
        end
        ST_WAIT: if (mem_rvalid_i) state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wb_we_o        = we_reg;
  assign wb_addr_o      = addr_reg;
  assign wb_data_o      = data_reg;
  assign retire_cnt_o   = cnt_reg;
  assign protocol_err_o = err_reg;

endmodule
